// File: rtl/hub75_scan_driver_if.sv
// -----------------------------------------------------------------------------
// hub75_scan_driver_if
//
// Purpose: bundles the two buses the HUB75 scan driver sits between.
//   Pixel side (driver <-> game/action logic):
//     row, col           address of the pixel pair being shifted (driver out)
//     red_up..blue_up    colour of pixel (row, col)              (upstream out)
//     red_down..blue_down colour of pixel (row+16, col)          (upstream out)
//     blank_req          force the panel dark, scanning continues (upstream out)
//   Panel side (driver -> LED panel):
//     R0,G0,B0,R1,G1,B1  serial colour data, upper/lower half
//     LED_CLK            shift clock, panel samples on its rising edge
//     STB                row latch strobe, active-high
//     OE                 output enable, active-low (1 = blank)
//     sel_ABCD           row currently displayed
//     frame_done         one-clk pulse after row 15 has been latched
//
// Modports: master = the scan driver, slave = its surroundings
// (upstream pixel source plus the panel).
// -----------------------------------------------------------------------------
interface hub75_scan_driver_if;
    logic [3:0] row;
    logic [4:0] col;
    logic       red_up;
    logic       green_up;
    logic       blue_up;
    logic       red_down;
    logic       green_down;
    logic       blue_down;
    logic       blank_req;
    logic       R0;
    logic       G0;
    logic       B0;
    logic       R1;
    logic       G1;
    logic       B1;
    logic       LED_CLK;
    logic       STB;
    logic       OE;
    logic [3:0] sel_ABCD;
    logic       frame_done;

    modport master (
        output row, col,
        input  red_up, green_up, blue_up, red_down, green_down, blue_down,
        input  blank_req,
        output R0, G0, B0, R1, G1, B1,
        output LED_CLK, STB, OE, sel_ABCD, frame_done
    );

    modport slave (
        input  row, col,
        output red_up, green_up, blue_up, red_down, green_down, blue_down,
        output blank_req,
        input  R0, G0, B0, R1, G1, B1,
        input  LED_CLK, STB, OE, sel_ABCD, frame_done
    );
endinterface

// File: rtl/hub75_scan_driver.sv
// -----------------------------------------------------------------------------
// hub75_scan_driver
//
// Purpose: scans a 32x32 HUB75 panel as two 16-row halves in parallel. For each
// row it walks col 0..31, fetching the upper/lower pixel colours from upstream
// and shifting them into the panel, then blanks, latches the row with STB and
// holds it on display for ON_TIME cycles. The next row is shifted while the
// previously latched row is still lit.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset; restarts the scan at row 0, col 0
//   bus    hub75_scan_driver_if.master (pixel address/colour bus, blank_req,
//          panel pins R0..B1, LED_CLK, STB, OE, sel_ABCD, frame_done)
//
// Parameters:
//   CLK_DIV    clk cycles per LED_CLK half-period (2..255)
//   STB_WIDTH  clk cycles STB is held high per latch (1..15)
//   ON_TIME    clk cycles of display-only time after each latch (1..65535)
//
// Row period = 64*CLK_DIV + 1 + STB_WIDTH + ON_TIME clk.
// All panel pins are registered.
// -----------------------------------------------------------------------------
module hub75_scan_driver #(
    parameter int CLK_DIV   = 2,
    parameter int STB_WIDTH = 2,
    parameter int ON_TIME   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    hub75_scan_driver_if.master  bus
);

    typedef enum logic [2:0] {
        SHIFT_LO,
        SHIFT_HI,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    // Terminal values of the per-state cycle counter.
    localparam logic [15:0] SHIFT_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] STB_LAST   = 16'(STB_WIDTH - 1);
    localparam logic [15:0] ON_LAST    = 16'(ON_TIME - 1);

    state_t      state;
    logic [15:0] cnt;
    logic        shown;
    logic [3:0]  row_q;
    logic [4:0]  col_q;
    logic [3:0]  sel_q;
    logic [5:0]  rgb_q;
    logic        led_clk_q;
    logic        stb_q;
    logic        oe_q;
    logic        frame_done_q;

    // Panel is dark while blanking/latching, before any row has ever been
    // latched (the shift registers hold garbage), or on upstream request.
    function automatic logic oe_level(input state_t st, input logic sh,
                                      input logic blk);
        oe_level = (st == BLANK) || (st == LATCH) || !sh || blk;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SHIFT_LO;
            cnt          <= 16'd0;
            shown        <= 1'b0;
            row_q        <= 4'd0;
            col_q        <= 5'd0;
            sel_q        <= 4'd0;
            rgb_q        <= 6'd0;
            led_clk_q    <= 1'b0;
            stb_q        <= 1'b0;
            oe_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt          <= cnt + 16'd1;
            frame_done_q <= 1'b0;
            oe_q         <= oe_level(state, shown, bus.blank_req);

            case (state)
                SHIFT_LO: begin
                    // The address changed on entry; upstream has had one clk
                    // to respond, so sample at the end of the first cycle.
                    // Data then leads the LED_CLK rise by CLK_DIV-1 clk.
                    if (cnt == 16'd0) begin
                        rgb_q <= {bus.red_up, bus.green_up, bus.blue_up,
                                  bus.red_down, bus.green_down, bus.blue_down};
                    end
                    if (cnt == SHIFT_LAST) begin
                        state     <= SHIFT_HI;
                        cnt       <= 16'd0;
                        led_clk_q <= 1'b1;
                        oe_q      <= oe_level(SHIFT_HI, shown, bus.blank_req);
                    end
                end

                SHIFT_HI: begin
                    if (cnt == SHIFT_LAST) begin
                        cnt       <= 16'd0;
                        led_clk_q <= 1'b0;
                        // 5-bit col wraps 31 -> 0 on its own.
                        col_q     <= col_q + 5'd1;
                        if (col_q == 5'd31) begin
                            state <= BLANK;
                            oe_q  <= oe_level(BLANK, shown, bus.blank_req);
                        end else begin
                            state <= SHIFT_LO;
                            oe_q  <= oe_level(SHIFT_LO, shown, bus.blank_req);
                        end
                    end
                end

                BLANK: begin
                    state <= LATCH;
                    cnt   <= 16'd0;
                    stb_q <= 1'b1;
                    sel_q <= row_q;
                    oe_q  <= oe_level(LATCH, shown, bus.blank_req);
                end

                LATCH: begin
                    if (cnt == STB_LAST) begin
                        state        <= DISPLAY;
                        cnt          <= 16'd0;
                        stb_q        <= 1'b0;
                        shown        <= 1'b1;
                        row_q        <= row_q + 4'd1;
                        frame_done_q <= (row_q == 4'd15);
                        oe_q         <= oe_level(DISPLAY, 1'b1, bus.blank_req);
                    end
                end

                DISPLAY: begin
                    if (cnt == ON_LAST) begin
                        state <= SHIFT_LO;
                        cnt   <= 16'd0;
                        oe_q  <= oe_level(SHIFT_LO, shown, bus.blank_req);
                    end
                end

                default: begin
                    state     <= SHIFT_LO;
                    cnt       <= 16'd0;
                    led_clk_q <= 1'b0;
                    stb_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.row        = row_q;
    assign bus.col        = col_q;
    assign bus.R0         = rgb_q[5];
    assign bus.G0         = rgb_q[4];
    assign bus.B0         = rgb_q[3];
    assign bus.R1         = rgb_q[2];
    assign bus.G1         = rgb_q[1];
    assign bus.B1         = rgb_q[0];
    assign bus.LED_CLK    = led_clk_q;
    assign bus.STB        = stb_q;
    assign bus.OE         = oe_q;
    assign bus.sel_ABCD   = sel_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_hub75_scan_driver
//
// Two instances: dut_a with default timing (row = 195 clk) and dut_b with
// CLK_DIV=3, STB_WIDTH=1, ON_TIME=10 (row = 204 clk). Each has an upstream
// pixel model driven from its row/col address. Expected pixel values are
// queued by the stimulus sequence in scan order and popped on every LED_CLK
// rising edge.
// -----------------------------------------------------------------------------
module tb_hub75_scan_driver;

    logic clk;
    logic rst_a;
    logic rst_b;

    hub75_scan_driver_if bus_a ();
    hub75_scan_driver_if bus_b ();

    hub75_scan_driver dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    hub75_scan_driver #(
        .CLK_DIV   (3),
        .STB_WIDTH (1),
        .ON_TIME   (10)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // cycles since reset release, one count per active edge
    int cyc;
    int cyc_b;
    always @(posedge clk or posedge rst_a) begin
        if (rst_a) cyc <= 0;
        else       cyc <= cyc + 1;
    end
    always @(posedge clk or posedge rst_b) begin
        if (rst_b) cyc_b <= 0;
        else       cyc_b <= cyc_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    // Pixel pattern, bit order {R0,G0,B0,R1,G1,B1}.
    // mode 0: all colours on; mode 1: red_up only at col 5;
    // mode 2: mixed pattern whose value differs between any two adjacent
    //         scan positions (bit 5 follows col[0]).
    function automatic logic [5:0] pix(input int m, input logic [3:0] r,
                                       input logic [4:0] c);
        case (m)
            0:       pix = 6'h3f;
            1:       pix = (c == 5'd5) ? 6'b100000 : 6'b000000;
            default: pix = {c[0], c[1], r[0] ^ c[2], ~c[0], r[1] ^ c[3],
                            c[4] ^ r[2] ^ r[3]};
        endcase
    endfunction

    // Upstream pixel sources
    int         mode_a;
    logic [5:0] up_a;
    logic [5:0] up_b;
    always_comb begin
        up_a = pix(mode_a, bus_a.row, bus_a.col);
        bus_a.red_up     = up_a[5];
        bus_a.green_up   = up_a[4];
        bus_a.blue_up    = up_a[3];
        bus_a.red_down   = up_a[2];
        bus_a.green_down = up_a[1];
        bus_a.blue_down  = up_a[0];
    end
    always_comb begin
        up_b = pix(2, bus_b.row, bus_b.col);
        bus_b.red_up     = up_b[5];
        bus_b.green_up   = up_b[4];
        bus_b.blue_up    = up_b[3];
        bus_b.red_down   = up_b[2];
        bus_b.green_down = up_b[1];
        bus_b.blue_down  = up_b[0];
    end
    assign bus_b.blank_req = 1'b0;

    wire [5:0] obs_a = {bus_a.R0, bus_a.G0, bus_a.B0, bus_a.R1, bus_a.G1, bus_a.B1};
    wire [5:0] obs_b = {bus_b.R0, bus_b.G0, bus_b.B0, bus_b.R1, bus_b.G1, bus_b.B1};

    // Scoreboards and event logs
    logic [5:0] sb_a[$];
    logic [5:0] sb_b[$];
    int rise_q[$];
    int stb_q[$];
    int sel_q[$];
    int fd_q[$];
    int b_rise_q[$];
    int b_stb_q[$];
    int b_pops = 0;
    int b_chg  = 0;
    int b_last_fall = -10;

    logic       led_prev_a, stb_prev_a;
    logic       led_prev_b, stb_prev_b;
    logic [5:0] dat_prev_b;
    logic [5:0] want_a, want_b;

    // Monitor for dut_a, sampled on the inactive edge
    always @(negedge clk) begin
        if (rst_a) begin
            led_prev_a = 1'b0;
            stb_prev_a = 1'b0;
        end else begin
            if (bus_a.LED_CLK && !led_prev_a) begin
                rise_q.push_back(cyc);
                chk("a_sb_nonempty", 32'(sb_a.size() != 0), 32'd1);
                if (sb_a.size() != 0) begin
                    want_a = sb_a.pop_front();
                    chk("a_pixel", 32'(obs_a), 32'(want_a));
                end
            end
            if (bus_a.STB && !stb_prev_a) begin
                stb_q.push_back(cyc);
                sel_q.push_back(int'(bus_a.sel_ABCD));
            end
            if (bus_a.frame_done) fd_q.push_back(cyc);
            led_prev_a = bus_a.LED_CLK;
            stb_prev_a = bus_a.STB;
        end
    end

    // Monitor for dut_b
    always @(negedge clk) begin
        if (rst_b) begin
            led_prev_b = 1'b0;
            stb_prev_b = 1'b0;
            dat_prev_b = 6'd0;
        end else begin
            if (bus_b.LED_CLK && !led_prev_b) begin
                b_rise_q.push_back(cyc_b);
                if (sb_b.size() != 0) begin
                    want_b = sb_b.pop_front();
                    b_pops++;
                    chk("b_pixel", 32'(obs_b), 32'(want_b));
                end
            end
            if (!bus_b.LED_CLK && led_prev_b) b_last_fall = cyc_b;
            if (bus_b.STB && !stb_prev_b) b_stb_q.push_back(cyc_b);
            // Data may only move one clk after a LED_CLK fall, or one clk
            // into a new row (row starts every 204 clk).
            if (cyc_b < 1020 && obs_b != dat_prev_b) begin
                b_chg++;
                chk("b_data_after_fall",
                    32'((cyc_b == b_last_fall + 1) || (cyc_b % 204 == 1)), 32'd1);
            end
            led_prev_b = bus_b.LED_CLK;
            stb_prev_b = bus_b.STB;
            dat_prev_b = obs_b;
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_row_a(input int m, input logic [3:0] r);
        for (int c = 0; c < 32; c++) sb_a.push_back(pix(m, r, 5'(c)));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_row"},  32'(bus_a.row), 32'd0);
        chk({tag, "_col"},  32'(bus_a.col), 32'd0);
        chk({tag, "_sel"},  32'(bus_a.sel_ABCD), 32'd0);
        chk({tag, "_rgb"},  32'(obs_a), 32'd0);
        chk({tag, "_led"},  32'(bus_a.LED_CLK), 32'd0);
        chk({tag, "_stb"},  32'(bus_a.STB), 32'd0);
        chk({tag, "_oe"},   32'(bus_a.OE), 32'd1);
        chk({tag, "_fd"},   32'(bus_a.frame_done), 32'd0);
    endtask

    // Called at the negedge right after reset release; covers the first
    // row's shift and latch window up to DISPLAY entry (cyc 131).
    task automatic row0_check();
        int oe_bad;
        int stb_hi;
        int gap_bad;
        oe_bad = 0;
        stb_hi = 0;
        gap_bad = 0;
        chk("r0_row", 32'(bus_a.row), 32'd0);
        chk("r0_col", 32'(bus_a.col), 32'd0);
        while (cyc < 131) begin
            if (bus_a.OE !== 1'b1) oe_bad++;
            if (bus_a.STB === 1'b1) stb_hi++;
            @(negedge clk);
        end
        chk("r0_oe_high_cycles_bad", 32'(oe_bad), 32'd0);
        chk("r0_oe_display", 32'(bus_a.OE), 32'd0);
        chk("r0_stb_display", 32'(bus_a.STB), 32'd0);
        chk("r0_stb_width", 32'(stb_hi), 32'd2);
        chk("r0_stb_first", 32'(stb_q.size() > 0 ? stb_q[0] : -1), 32'd129);
        chk("r0_rise_count", 32'(rise_q.size()), 32'd32);
        chk("r0_first_rise", 32'(rise_q.size() > 0 ? rise_q[0] : -1), 32'd2);
        for (int i = 1; i < rise_q.size(); i++)
            if (rise_q[i] - rise_q[i-1] != 4) gap_bad++;
        chk("r0_rise_gap_bad", 32'(gap_bad), 32'd0);
    endtask

    initial begin
        int gap_bad;
        int oe_bad;
        int d_cyc;

        rst_a = 1'b1;
        rst_b = 1'b1;
        mode_a = 0;
        bus_a.blank_req = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_values("rst0");

        // Expected pixels: dut_a row 0 all-on, dut_b rows 0..4 pattern.
        push_row_a(0, 4'd0);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 32; c++) sb_b.push_back(pix(2, 4'(r), 5'(c)));

        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        row0_check();

        // Free run: during each row's DISPLAY choose the next row's pattern.
        for (int r = 0; r <= 40; r++) begin
            wait_cyc(195 * r + 150);
            chk("a_sb_drained", 32'(sb_a.size()), 32'd0);
            mode_a = (r < 2) ? 1 : 2;
            push_row_a(mode_a, 4'((r + 1) % 16));

            if (r == 5) begin
                chk("b_sb_drained", 32'(sb_b.size()), 32'd0);
                chk("b_pops", 32'(b_pops), 32'd160);
                chk("b_data_changes", 32'(b_chg), 32'd160);
                chk("b_stb_count", 32'(b_stb_q.size()), 32'd5);
                chk("b_stb_first", 32'(b_stb_q.size() > 0 ? b_stb_q[0] : -1), 32'd193);
                gap_bad = 0;
                for (int i = 1; i < b_stb_q.size(); i++)
                    if (b_stb_q[i] - b_stb_q[i-1] != 204) gap_bad++;
                chk("b_row_period_bad", 32'(gap_bad), 32'd0);
                chk("b_first_rise", 32'(b_rise_q.size() > 0 ? b_rise_q[0] : -1), 32'd3);
                gap_bad = 0;
                for (int i = 1; i < 32 && i < b_rise_q.size(); i++)
                    if (b_rise_q[i] - b_rise_q[i-1] != 6) gap_bad++;
                chk("b_led_period_bad", 32'(gap_bad), 32'd0);
            end

            if (r == 16) begin
                chk("sel_count", 32'(sel_q.size()), 32'd17);
                for (int i = 0; i < 17 && i < sel_q.size(); i++)
                    chk("sel_step", 32'(sel_q[i]), 32'(i % 16));
            end

            if (r == 17) begin
                d_cyc = 195 * 17 + 160;
                wait_cyc(d_cyc);
                chk("blank_before", 32'(bus_a.OE), 32'd0);
                bus_a.blank_req = 1'b1;
                @(negedge clk);
                chk("blank_next_clk", 32'(bus_a.OE), 32'd1);
                oe_bad = 0;
                while (cyc < d_cyc + 100) begin
                    if (bus_a.OE !== 1'b1) oe_bad++;
                    @(negedge clk);
                end
                chk("blank_hold_bad", 32'(oe_bad), 32'd0);
                bus_a.blank_req = 1'b0;
                chk("blank_release_same", 32'(bus_a.OE), 32'd1);
                @(negedge clk);
                chk("blank_release_next", 32'(bus_a.OE), 32'd0);
            end

            if (r == 32) begin
                chk("fd_count", 32'(fd_q.size()), 32'd2);
                chk("fd_first", 32'(fd_q.size() > 0 ? fd_q[0] : -1), 32'd3056);
                chk("fd_second", 32'(fd_q.size() > 1 ? fd_q[1] : -1), 32'd6176);
            end
        end

        // Reset in SHIFT_HI of frame row 9, col 17 (second high cycle).
        wait_cyc(195 * 41 + 71);
        chk("pre_rst_row", 32'(bus_a.row), 32'd9);
        chk("pre_rst_col", 32'(bus_a.col), 32'd17);
        chk("pre_rst_led", 32'(bus_a.LED_CLK), 32'd1);
        rst_a = 1'b1;
        #1;
        check_reset_values("rst_mid");
        sb_a.delete();
        rise_q.delete();
        stb_q.delete();
        sel_q.delete();
        repeat (2) @(negedge clk);
        push_row_a(mode_a, 4'd0);
        rst_a = 1'b0;
        row0_check();
        wait_cyc(150);
        chk("rst_sb_drained", 32'(sb_a.size()), 32'd0);
        chk("rst_sel_first", 32'(sel_q.size() > 0 ? sel_q[0] : -1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
